// File: rtl/task_dispatcher.sv
// Pops task words from an upstream FIFO into a 2-entry stage and hands each one
// to an idle worker, picking among idle workers in round-robin order.
module task_dispatcher #(
    parameter int unsigned WIDTH       = 40,
    parameter int unsigned NUM_WORKERS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [3:0]             fifo_count,
    output logic                   fifo_ren,
    input  logic [WIDTH-1:0]       fifo_rdata,
    input  logic [NUM_WORKERS-1:0] worker_idle,
    output logic [NUM_WORKERS-1:0] worker_start,
    output logic [WIDTH-1:0]       worker_data,
    output logic [15:0]            dispatch_count
);

    localparam int unsigned PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int unsigned CNT_W = 16;

    logic [WIDTH-1:0]       stage_q [2];
    logic [WIDTH-1:0]       stage_d [2];
    logic [1:0]             occ_q, occ_d, occ_rem;
    logic                   inflight_q, inflight_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d, grant;
    logic [NUM_WORKERS-1:0] worker_start_q, worker_start_d, eligible;
    logic [WIDTH-1:0]       worker_data_q, worker_data_d;
    logic [CNT_W-1:0]       dispatch_count_q, dispatch_count_d;
    logic                   found, dispatch;
    int unsigned            idx;

    // Only pop when the count excludes any outstanding pop and the stage has a slot for the word.
    assign fifo_ren = !reset
                      && (fifo_count > {3'b000, inflight_q})
                      && ((occ_q + {1'b0, inflight_q}) < 2'd2);

    // Round-robin search upward from ptr over workers that are idle and not just started.
    always_comb begin
        eligible = worker_idle & ~worker_start_q;
        found    = 1'b0;
        grant    = '0;
        idx      = 0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NUM_WORKERS) begin
                idx = idx - NUM_WORKERS;
            end
            if (!found && eligible[PTR_W'(idx)]) begin
                found = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

    // Stage pop/capture, grant registration and pointer advance.
    always_comb begin
        dispatch         = (occ_q != 2'd0) && found;
        stage_d[0]       = stage_q[0];
        stage_d[1]       = stage_q[1];
        occ_rem          = occ_q;
        worker_start_d   = '0;
        worker_data_d    = worker_data_q;
        ptr_d            = ptr_q;
        dispatch_count_d = dispatch_count_q;
        inflight_d       = fifo_ren;

        if (dispatch) begin
            stage_d[0]       = stage_q[1];
            occ_rem          = occ_q - 2'd1;
            worker_start_d   = NUM_WORKERS'(1) << grant;
            worker_data_d    = stage_q[0];
            ptr_d            = (grant == PTR_W'(NUM_WORKERS - 1)) ? '0 : grant + PTR_W'(1);
            dispatch_count_d = dispatch_count_q + CNT_W'(1);
        end

        // The returning word lands behind whatever remains, keeping strict order.
        if (inflight_q) begin
            if (occ_rem == 2'd0) begin
                stage_d[0] = fifo_rdata;
            end else begin
                stage_d[1] = fifo_rdata;
            end
        end
        occ_d = occ_rem + {1'b0, inflight_q};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q[0]       <= '0;
            stage_q[1]       <= '0;
            occ_q            <= '0;
            inflight_q       <= 1'b0;
            ptr_q            <= '0;
            worker_start_q   <= '0;
            worker_data_q    <= '0;
            dispatch_count_q <= '0;
        end else begin
            stage_q[0]       <= stage_d[0];
            stage_q[1]       <= stage_d[1];
            occ_q            <= occ_d;
            inflight_q       <= inflight_d;
            ptr_q            <= ptr_d;
            worker_start_q   <= worker_start_d;
            worker_data_q    <= worker_data_d;
            dispatch_count_q <= dispatch_count_d;
        end
    end

    assign worker_start   = worker_start_q;
    assign worker_data    = worker_data_q;
    assign dispatch_count = dispatch_count_q;

endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: queue-based FIFO/worker environment, a per-cycle
// reference model of the dispatch rules, and end-to-end ordering scoreboard.
module tb_task_dispatcher;

    localparam int unsigned W = 40;
    localparam int unsigned N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    fifo_count;
    logic          fifo_ren;
    logic [W-1:0]  fifo_rdata;
    logic [N-1:0]  worker_idle;
    logic [N-1:0]  worker_start;
    logic [W-1:0]  worker_data;
    logic [15:0]   dispatch_count;

    task_dispatcher #(.WIDTH(W), .NUM_WORKERS(N)) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo_count     (fifo_count),
        .fifo_ren       (fifo_ren),
        .fifo_rdata     (fifo_rdata),
        .worker_idle    (worker_idle),
        .worker_start   (worker_start),
        .worker_data    (worker_data),
        .dispatch_count (dispatch_count)
    );

    always #5 clock = ~clock;

    logic [W-1:0] bfifo[$];
    logic [W-1:0] sb[$];
    bit           ren_s, rst_s;
    logic [N-1:0] start_s;
    logic [N-1:0] auto_drop;
    int           n_checks, n_fail;
    int           ren_pulses, pops, starts_seen;
    int           grants[$];

    logic [W-1:0] m_stage[$];
    bit           m_inflight;
    int           m_ptr;
    logic [N-1:0] m_start;
    logic [W-1:0] m_data;
    logic [15:0]  m_count;
    bit           m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle: compare DUT against the model, then advance the model by one clock.
    always @(negedge clock) begin
        logic         exp_ren;
        logic [N-1:0] elig;
        int           g;
        int           j;
        bit           f;
        ren_s   = fifo_ren;
        rst_s   = reset;
        start_s = worker_start;
        exp_ren = 1'b0;
        if (fifo_ren) ren_pulses++;
        if (m_valid) begin
            exp_ren = !reset && (fifo_count > m_inflight)
                      && ((m_stage.size() + int'(m_inflight)) < 2);
            chk("fifo_ren", 64'(fifo_ren), 64'(exp_ren));
            chk("worker_start", 64'(worker_start), 64'(m_start));
            chk("worker_data", 64'(worker_data), 64'(m_data));
            chk("dispatch_count", 64'(dispatch_count), 64'(m_count));
            if (worker_start != '0) begin
                starts_seen++;
                for (int k = 0; k < N; k++) if (worker_start[k]) grants.push_back(k);
                if (sb.size() > 0) begin
                    chk("order", 64'(worker_data), 64'(sb.pop_front()));
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL order: start with no task pending, data %0h", worker_data);
                end
            end
        end
        if (reset) begin
            m_stage.delete();
            m_inflight = 1'b0;
            m_ptr      = 0;
            m_start    = '0;
            m_data     = '0;
            m_count    = '0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            elig = worker_idle & ~m_start;
            f = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!f && elig[j]) begin
                    f = 1'b1;
                    g = j;
                end
            end
            if (m_stage.size() > 0 && f) begin
                m_start = N'(1) << g;
                m_data  = m_stage.pop_front();
                m_ptr   = (g + 1) % N;
                m_count = m_count + 16'd1;
            end else begin
                m_start = '0;
            end
            if (m_inflight) m_stage.push_back(fifo_rdata);
            m_inflight = exp_ren;
        end
    end

    // Environment: FIFO read port with one-cycle latency, workers dropping idle after a start.
    always @(posedge clock) begin
        #1;
        if (rst_s) begin
            bfifo.delete();
            sb.delete();
        end else if (ren_s) begin
            if (bfifo.size() > 0) begin
                fifo_rdata = bfifo.pop_front();
                pops++;
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL over_read: pop issued against empty FIFO at %0t", $time);
            end
        end
        for (int k = 0; k < N; k++) if (start_s[k] && auto_drop[k]) worker_idle[k] = 1'b0;
        #3;
        fifo_count = (bfifo.size() > 15) ? 4'd15 : 4'(bfifo.size());
    end

    task automatic at_step();
        @(posedge clock);
        #3;
    endtask

    task automatic wait_steps(input int n);
        repeat (n) at_step();
    endtask

    task automatic do_reset();
        at_step();
        reset = 1'b1;
        at_step();
        reset = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] w);
        bfifo.push_back(w);
        sb.push_back(w);
    endtask

    initial begin
        int exp_g[6];
        exp_g = '{0, 1, 2, 3, 0, 1};
        worker_idle = '0;
        auto_drop   = '0;
        fifo_rdata  = '0;
        fifo_count  = '0;
        wait_steps(3);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("reset_start", 64'(worker_start), 64'h0);
        chk("reset_data", 64'(worker_data), 64'h0);
        chk("reset_count", 64'(dispatch_count), 64'h0);
        chk("reset_ren", 64'(fifo_ren), 64'h0);

        // Single task: pop, capture, decide, start three cycles after the pop.
        at_step();
        worker_idle = 4'hF;
        at_step();
        ren_pulses = 0;
        push(40'h123456789a);
        repeat (4) @(negedge clock);
        #1;
        chk("single_start", 64'(worker_start), 64'h1);
        chk("single_data", 64'(worker_data), 64'h123456789a);
        chk("single_count", 64'(dispatch_count), 64'd1);
        wait_steps(4);
        chk("single_ren_pulses", 64'(ren_pulses), 64'd1);

        // Round robin across all-idle workers.
        do_reset();
        grants.delete();
        for (int i = 0; i < 6; i++) push(40'(64'h00a0_0000_0000 + i));
        wait_steps(20);
        chk("rr_num_grants", 64'(grants.size()), 64'd6);
        for (int i = 0; i < 6; i++) if (i < grants.size()) chk("rr_grant", 64'(grants[i]), 64'(exp_g[i]));
        chk("rr_count", 64'(dispatch_count), 64'd6);

        // Masking: only worker 2 idle, it drops idle after each start.
        do_reset();
        worker_idle = 4'b0100;
        auto_drop   = 4'b0100;
        starts_seen = 0;
        grants.delete();
        push(40'hb0b0_0000_01);
        push(40'hb0b0_0000_02);
        wait_steps(12);
        chk("mask_starts1", 64'(starts_seen), 64'd1);
        chk("mask_idle_dropped", 64'(worker_idle), 64'h0);
        chk("mask_count1", 64'(dispatch_count), 64'd1);
        worker_idle = 4'b0100;
        wait_steps(6);
        chk("mask_starts2", 64'(starts_seen), 64'd2);
        if (grants.size() > 1) begin
            chk("mask_grant0", 64'(grants[0]), 64'd2);
            chk("mask_grant1", 64'(grants[1]), 64'd2);
        end
        auto_drop = '0;

        // Over-read guard: a single queued word is popped exactly once.
        worker_idle = '0;
        do_reset();
        pops = 0;
        ren_pulses = 0;
        push(40'hc0ffee0001);
        wait_steps(6);
        chk("one_word_pops", 64'(pops), 64'd1);
        chk("one_word_ren", 64'(ren_pulses), 64'd1);

        // Stall with 5 queued: stage fills with exactly two pops.
        do_reset();
        pops = 0;
        for (int i = 0; i < 5; i++) push(40'(64'h00d0_0000_0000 + i));
        wait_steps(8);
        chk("stall_pops", 64'(pops), 64'd2);
        chk("stall_ren", 64'(fifo_ren), 64'h0);
        chk("stall_fifo_count", 64'(fifo_count), 64'd3);

        // Reset with a full stage: staged words must never surface.
        do_reset();
        chk("midrst_start", 64'(worker_start), 64'h0);
        chk("midrst_count", 64'(dispatch_count), 64'h0);
        worker_idle = 4'hF;
        push(40'h00000000aa);
        repeat (4) @(negedge clock);
        #1;
        chk("midrst_new_start", 64'(worker_start), 64'h1);
        chk("midrst_new_data", 64'(worker_data), 64'haa);
        chk("midrst_new_count", 64'(dispatch_count), 64'd1);

        // Counter wrap from 16'hffff.
        do_reset();
        force dut.dispatch_count_q = 16'hffff;
        m_count = 16'hffff;
        at_step();
        release dut.dispatch_count_q;
        push(40'h5a5a5a5a5a);
        repeat (4) @(negedge clock);
        #1;
        chk("wrap_start", 64'(worker_start), 64'h1);
        chk("wrap_count", 64'(dispatch_count), 64'h0);

        wait_steps(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
